// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and default sizing for the scan-load/unload controller.
package scan_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} scan_state_e;

   localparam int unsigned                   SCAN_CHAIN_LEN = 8;
   localparam logic [SCAN_CHAIN_LEN-1:0]     SCAN_RST_VAL   = 8'h3F;

endpackage

// File: rtl/scan_ff_chain.sv
// Bank of resettable, enable-gated flops with a serial scan path (q[0] is the scan input end).
module scan_ff_chain
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned          CHAIN_LEN = SCAN_CHAIN_LEN,
   parameter logic [CHAIN_LEN-1:0] RST_VAL   = CHAIN_LEN'(SCAN_RST_VAL)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 scan_enable,
   input  logic                 scan_in,
   input  logic [CHAIN_LEN-1:0] func_din,
   input  logic                 func_en,
   input  logic                 sync_clr,
   output logic [CHAIN_LEN-1:0] q,
   output logic                 scan_out
);

   logic [CHAIN_LEN-1:0] q_q, q_d;

   // Scan shifting overrides both functional controls.
   always_comb begin
      q_d = q_q;
      if (scan_enable) begin
         q_d = {q_q[CHAIN_LEN-2:0], scan_in};
      end else if (sync_clr) begin
         q_d = '0;
      end else if (func_en) begin
         q_d = func_din;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q        = q_q;
   assign scan_out = q_q[CHAIN_LEN-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan pass controller: shifts a parallel word into the chain MSB-first while capturing the old contents.
module scan_chain_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned          CHAIN_LEN = SCAN_CHAIN_LEN,
   parameter logic [CHAIN_LEN-1:0] RST_VAL   = CHAIN_LEN'(SCAN_RST_VAL)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] load_data,
   input  logic [CHAIN_LEN-1:0] func_din,
   input  logic                 func_en,
   input  logic                 sync_clr,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] unload_data,
   output logic                 scan_enable,
   output logic [CHAIN_LEN-1:0] q
);

   localparam int unsigned    CW       = $clog2(CHAIN_LEN);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CHAIN_LEN - 1);

   scan_state_e          state_q, state_d;
   logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
   logic [CHAIN_LEN-1:0] cap_q, cap_d;
   logic [CHAIN_LEN-1:0] unload_q, unload_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 se_q, se_d;
   logic                 scan_out;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cap_d    = cap_q;
      unload_d = unload_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               shreg_d = load_data;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            shreg_d = shreg_q << 1;
            cap_d   = {cap_q[CHAIN_LEN-2:0], scan_out};
            // The last captured bit enters on the final shift edge, so unload takes the shifted value.
            if (cnt_q == CNT_LAST) begin
               state_d  = DONE;
               unload_d = {cap_q[CHAIN_LEN-2:0], scan_out};
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      se_d = (state_d == SHIFT);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         cap_q    <= '0;
         unload_q <= '0;
         cnt_q    <= '0;
         se_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cap_q    <= cap_d;
         unload_q <= unload_d;
         cnt_q    <= cnt_d;
         se_q     <= se_d;
      end
   end

   scan_ff_chain #(
      .CHAIN_LEN (CHAIN_LEN),
      .RST_VAL   (RST_VAL)
   ) u_chain (
      .clk         (clk),
      .rstn        (rstn),
      .scan_enable (se_q),
      .scan_in     (shreg_q[CHAIN_LEN-1]),
      .func_din    (func_din),
      .func_en     (func_en),
      .sync_clr    (sync_clr),
      .q           (q),
      .scan_out    (scan_out)
   );

   assign busy        = (state_q == SHIFT);
   assign done        = (state_q == DONE);
   assign scan_enable = se_q;
   assign unload_data = unload_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: directed scenarios plus random traffic against a pass-level reference model.
module tb_scan_chain_ctrl;

   localparam int          N    = 8;
   localparam logic [N-1:0] RSTV = 8'h3F;

   logic         clk = 1'b0;
   logic         rstn, start, func_en, sync_clr;
   logic [N-1:0] load_data, func_din;
   logic         busy, done, scan_enable;
   logic [N-1:0] unload_data, q;

   scan_chain_ctrl #(
      .CHAIN_LEN (N),
      .RST_VAL   (RSTV)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .load_data   (load_data),
      .func_din    (func_din),
      .func_en     (func_en),
      .sync_clr    (sync_clr),
      .busy        (busy),
      .done        (done),
      .unload_data (unload_data),
      .scan_enable (scan_enable),
      .q           (q)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int se_cnt = 0;
   int done_cnt = 0;
   bit check_en = 1'b0;

   // Model: mode 0 idle, 1 shifting (k edges taken), 2 done cycle.
   int           m_mode = 0;
   int           m_k = 0;
   logic [N-1:0] m_q = RSTV, m_unload = '0, m_P = '0, m_L = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         m_mode = 0; m_k = 0; m_q = RSTV; m_unload = '0;
      end else begin
         case (m_mode)
            0: begin
               if (sync_clr) m_q = '0;
               else if (func_en) m_q = func_din;
               if (start) begin
                  m_mode = 1; m_k = 0; m_L = load_data; m_P = m_q;
               end
            end
            1: begin
               m_k++;
               // After k shifts the chain holds the old word moved up k places with the top k bits of the new word below it.
               m_q = (m_P << m_k) | (m_L >> (N - m_k));
               if (m_k == N) begin
                  m_mode = 2; m_unload = m_P;
               end
            end
            default: begin
               if (sync_clr) m_q = '0;
               else if (func_en) m_q = func_din;
               m_mode = 0;
            end
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      if (check_en) begin
         chk("busy", busy, m_mode == 1);
         chk("scan_enable", scan_enable, m_mode == 1);
         chk("done", done, m_mode == 2);
         chk("q", q, m_q);
         chk("unload_data", unload_data, m_unload);
         if (scan_enable) se_cnt++;
         if (done) done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic pulse_start(input logic [N-1:0] ld);
      @(negedge clk);
      se_cnt = 0; done_cnt = 0;
      start = 1'b1; load_data = ld;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (done !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) chk("done_seen", done, 1);
      @(negedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; func_en = 1'b0; sync_clr = 1'b0;
      load_data = '0; func_din = '0;
      repeat (2) @(posedge clk);
      check_en = 1'b1;
      @(negedge clk); #2 rstn = 1'b1;

      // Reset state held through idle cycles
      repeat (3) @(negedge clk);
      #1;
      chk("t1_q", q, 8'h3F);
      chk("t1_unload", unload_data, 8'h00);
      chk("t1_busy", busy, 0);
      chk("t1_done", done, 0);
      chk("t1_se", scan_enable, 0);

      // First pass after reset
      pulse_start(8'hA5);
      wait_done();
      chk("t2_se_cycles", se_cnt, 8);
      chk("t2_done_pulses", done_cnt, 1);
      chk("t2_q", q, 8'hA5);
      chk("t2_unload", unload_data, 8'h3F);

      // Functional load then pass
      @(negedge clk); func_en = 1'b1; func_din = 8'h5A;
      @(negedge clk); func_en = 1'b0;
      pulse_start(8'h0F);
      wait_done();
      chk("t3_unload", unload_data, 8'h5A);
      chk("t3_q", q, 8'h0F);

      // Start re-pulsed and functional controls held during a pass
      @(negedge clk); func_en = 1'b1; sync_clr = 1'b1; func_din = 8'hE7;
      pulse_start(8'h96);
      for (int i = 1; i <= N; i++) begin
         start = (i == 3 || i == 8);
         @(negedge clk);
      end
      start = 1'b0;
      chk("t4_done_now", done, 1);
      func_en = 1'b0; sync_clr = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("t4_q", q, 8'h96);
      chk("t4_unload", unload_data, 8'h00);
      chk("t4_se_cycles", se_cnt, 8);
      chk("t4_done_pulses", done_cnt, 1);
      chk("t4_busy", busy, 0);

      // Reset in the middle of a pass
      pulse_start(8'hFF);
      repeat (3) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("t5_q_rst", q, 8'h3F);
      chk("t5_unload_rst", unload_data, 8'h00);
      chk("t5_busy_rst", busy, 0);
      chk("t5_se_rst", scan_enable, 0);
      @(negedge clk); #2 rstn = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("t5_no_done", done_cnt, 0);
      pulse_start(8'h3C);
      wait_done();
      chk("t5_q", q, 8'h3C);
      chk("t5_unload", unload_data, 8'h3F);

      // sync_clr coinciding with start
      @(negedge clk); func_en = 1'b1; func_din = 8'hC3;
      @(negedge clk); func_en = 1'b0;
      #1 chk("t6_q_pre", q, 8'hC3);
      @(negedge clk); start = 1'b1; sync_clr = 1'b1; load_data = 8'h77;
      @(negedge clk); start = 1'b0; sync_clr = 1'b0;
      wait_done();
      chk("t6_unload", unload_data, 8'h00);
      chk("t6_q", q, 8'h77);

      // Random traffic checked cycle by cycle against the model
      repeat (400) begin
         @(negedge clk);
         start     = ($urandom_range(3) == 0);
         func_en   = $urandom_range(1) == 1;
         sync_clr  = ($urandom_range(7) == 0);
         load_data = N'($urandom);
         func_din  = N'($urandom);
         if ($urandom_range(149) == 0) begin
            #2 rstn = 1'b0;
            @(negedge clk);
            #2 rstn = 1'b1;
         end
      end

      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
